// File: rtl/regfile_write_scheduler.sv
// Merges Ex and Mem writebacks into the single register-file write port in program order,
// and reports pending-write hazards for the decode-stage query registers.

module regfile_write_scheduler_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned SEQ_W  = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushRW,
    input  logic [DATA_W-1:0] pushData,
    input  logic [SEQ_W-1:0]  pushTag,
    input  logic              pop,
    input  logic [ADDR_W-1:0] queryA,
    input  logic [ADDR_W-1:0] queryB,
    output logic              notFull,
    output logic              notEmpty,
    output logic [ADDR_W-1:0] headRW,
    output logic [DATA_W-1:0] headData,
    output logic [SEQ_W-1:0]  headTag,
    output logic              hitA,
    output logic              hitB
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] rwQ   [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];
    logic [SEQ_W-1:0]  tagQ  [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  offset;

    assign notFull  = count < CNT_W'(DEPTH);
    assign notEmpty = count != '0;
    assign headRW   = rwQ[rdPtr];
    assign headData = dataQ[rdPtr];
    assign headTag  = tagQ[rdPtr];

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            rwQ[wrPtr]   <= pushRW;
            dataQ[wrPtr] <= pushData;
            tagQ[wrPtr]  <= pushTag;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        hitA   = 1'b0;
        hitB   = 1'b0;
        offset = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset = PTR_W'(PTR_W'(i) - rdPtr);
            if (CNT_W'(offset) < count) begin
                if (rwQ[i] == queryA) hitA = 1'b1;
                if (rwQ[i] == queryB) hitB = 1'b1;
            end
        end
    end
endmodule

module regfile_write_scheduler #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ExValid,
    input  logic [ADDR_W-1:0] ExRW,
    input  logic [DATA_W-1:0] ExData,
    output logic              ExReady,
    input  logic              MemValid,
    input  logic [ADDR_W-1:0] MemRW,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    output logic              RegWr,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    input  logic [ADDR_W-1:0] QueryRA,
    input  logic [ADDR_W-1:0] QueryRB,
    output logic              HazardA,
    output logic              HazardB
);
    localparam int unsigned SEQ_W = $clog2(2 * DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic              exPush, memPush, exPop, memPop;
    logic              exNotEmpty, memNotEmpty;
    logic [ADDR_W-1:0] exHeadRW, memHeadRW;
    logic [DATA_W-1:0] exHeadData, memHeadData;
    logic [SEQ_W-1:0]  exHeadTag, memHeadTag, exTag, tagDiff, seqCnt;
    logic              exHitA, exHitB, memHitA, memHitB;

    // Zero-register writes are acknowledged but never stored or numbered.
    assign exPush  = ExValid && ExReady && (ExRW != ZERO_IDX);
    assign memPush = MemValid && MemReady && (MemRW != ZERO_IDX);
    assign exTag   = memPush ? seqCnt + SEQ_W'(1) : seqCnt;

    // Wrap-aware age: a negative Ex-minus-Mem tag distance means the Ex head is older.
    assign tagDiff = exHeadTag - memHeadTag;
    assign exPop   = exNotEmpty && (!memNotEmpty || tagDiff[SEQ_W-1]);
    assign memPop  = memNotEmpty && !exPop;

    regfile_write_scheduler_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
    ) exFifo (
        .Clk(Clk), .Reset(Reset), .push(exPush), .pushRW(ExRW), .pushData(ExData),
        .pushTag(exTag), .pop(exPop), .queryA(QueryRA), .queryB(QueryRB),
        .notFull(ExReady), .notEmpty(exNotEmpty), .headRW(exHeadRW),
        .headData(exHeadData), .headTag(exHeadTag), .hitA(exHitA), .hitB(exHitB)
    );

    regfile_write_scheduler_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)
    ) memFifo (
        .Clk(Clk), .Reset(Reset), .push(memPush), .pushRW(MemRW), .pushData(MemData),
        .pushTag(seqCnt), .pop(memPop), .queryA(QueryRA), .queryB(QueryRB),
        .notFull(MemReady), .notEmpty(memNotEmpty), .headRW(memHeadRW),
        .headData(memHeadData), .headTag(memHeadTag), .hitA(memHitA), .hitB(memHitB)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            seqCnt <= '0;
            RegWr  <= 1'b0;
            RW     <= '0;
            BusW   <= '0;
        end else begin
            seqCnt <= seqCnt + SEQ_W'(exPush) + SEQ_W'(memPush);
            RegWr  <= exPop || memPop;
            if (exPop) begin
                RW   <= exHeadRW;
                BusW <= exHeadData;
            end else if (memPop) begin
                RW   <= memHeadRW;
                BusW <= memHeadData;
            end
        end
    end

    // The in-flight write still counts until the file captures it on the falling edge.
    assign HazardA = (QueryRA != ZERO_IDX) && (exHitA || memHitA || (RegWr && RW == QueryRA));
    assign HazardB = (QueryRB != ZERO_IDX) && (exHitB || memHitB || (RegWr && RW == QueryRB));
endmodule
